// File: rtl/conv_out_packer_pkg.sv
// ============================================================================
// Module      : conv_out_packer_pkg
// Description : Shared constants, drain FSM encoding and bit helpers for the
//               convolutional-code output packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_out_packer_pkg;

  localparam int NUM_STREAMS = 3;
  localparam int BYTE_W      = 8;
  localparam int CNT_W       = $clog2(BYTE_W);

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t IDLE = 2'd0;
  localparam drain_state_t S0   = 2'd1;
  localparam drain_state_t S1   = 2'd2;
  localparam drain_state_t S2   = 2'd3;

  localparam int D0 = 0;
  localparam int D1 = 1;
  localparam int D2 = 2;

  function automatic logic [BYTE_W-1:0] set_bit(input logic [BYTE_W-1:0] value,
                                                input logic [CNT_W-1:0]  pos,
                                                input logic              bit_in);
    logic [BYTE_W-1:0] result;
    result      = value;
    result[pos] = bit_in;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_out_packer_stream_acc8.sv
// ============================================================================
// Module      : stream_acc8
// Description : One 8-bit LSB-first bit accumulator with bit write, clear and
//               a parallel read that already includes the bit being written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_acc8
  import conv_out_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [CNT_W-1:0]  bit_pos,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] acc_data
);

  logic [BYTE_W-1:0] r_acc;

  // The read port shows the in-flight bit so a completing symbol lands in the byte.
  always_comb begin
    acc_data = wr_en ? set_bit(r_acc, bit_pos, bit_in) : r_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= acc_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_out_packer.sv
// ============================================================================
// Module      : conv_out_packer
// Description : Packs the three coded streams LSB-first into bytes and drains
//               them d0, d1, d2 into a byte FIFO with back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_out_packer
  import conv_out_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [NUM_STREAMS-1:0] in_d,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   out_full,
  output logic                   out_wrreq,
  output logic [BYTE_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   blk_done
);

  logic [CNT_W-1:0]  r_bit_cnt;
  drain_state_t      r_state;
  drain_state_t      w_state_nxt;
  logic [BYTE_W-1:0] r_hold [NUM_STREAMS];
  logic              r_hold_last;
  logic              r_blk_done;
  logic [BYTE_W-1:0] w_acc [NUM_STREAMS];

  logic w_accept;
  logic w_group_end;
  logic w_complete;
  logic w_hold_busy;
  logic w_wr_accept;

  assign w_group_end = (r_bit_cnt == CNT_W'(BYTE_W - 1)) || in_last;
  assign w_hold_busy = (r_state != IDLE);
  assign w_wr_accept = w_hold_busy && !out_full;
  // A completing symbol may enter only while the last held byte leaves.
  assign in_ready    = !(w_hold_busy && w_group_end) || ((r_state == S2) && !out_full);
  assign w_accept    = in_valid && in_ready;
  assign w_complete  = w_accept && w_group_end;
  assign blk_done    = r_blk_done;

  generate
    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_acc
      stream_acc8 u_acc (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_accept),
        .clr      (w_complete),
        .bit_pos  (r_bit_cnt),
        .bit_in   (in_d[gi]),
        .acc_data (w_acc[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_hold_last <= 1'b0;
      r_blk_done  <= 1'b0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        r_hold[s] <= '0;
      end
    end else begin
      r_blk_done <= w_wr_accept && (r_state == S2) && r_hold_last;
      if (w_accept) begin
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_complete) begin
        r_hold_last <= in_last;
        for (int s = 0; s < NUM_STREAMS; s++) begin
          r_hold[s] <= w_acc[s];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_complete)  w_state_nxt = S0;
      S0:      if (w_wr_accept) w_state_nxt = S1;
      S1:      if (w_wr_accept) w_state_nxt = S2;
      S2:      if (w_wr_accept) w_state_nxt = w_complete ? S0 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_wrreq = w_wr_accept;
    out_data  = '0;
    out_last  = 1'b0;
    case (r_state)
      S0:      out_data = r_hold[D0];
      S1:      out_data = r_hold[D1];
      S2: begin
        out_data = r_hold[D2];
        out_last = r_hold_last;
      end
      default: out_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_out_packer.sv
// ============================================================================
// Module      : tb_conv_out_packer
// Description : Self-checking bench for conv_out_packer against a queue-based
//               byte model of the packing rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_out_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_d;
  logic       in_last;
  logic       in_ready;
  logic       out_full;
  logic       out_wrreq;
  logic [7:0] out_data;
  logic       out_last;
  logic       blk_done;

  conv_out_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_d      (in_d),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_full  (out_full),
    .out_wrreq (out_wrreq),
    .out_data  (out_data),
    .out_last  (out_last),
    .blk_done  (blk_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } wr_t;

  wr_t        exp_q[$];
  int         m_cnt;
  logic [7:0] m_byte [3];
  logic       exp_done;
  int         vectors;
  int         miscompares;
  int         n_writes;
  int         n_done;
  int         n_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt    = 0;
    exp_done = 1'b0;
    for (int s = 0; s < 3; s++) m_byte[s] = 8'h00;
  endtask

  // One clock: compare at the falling edge, then advance the model.
  task automatic tick(output bit accepted);
    logic exp_ready;
    logic wr;
    wr_t  f;
    @(negedge clk);
    exp_ready = !(exp_q.size() > 0 && (m_cnt == 7 || in_last)) ||
                (exp_q.size() == 1 && !out_full);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("blk_done", 32'(blk_done), 32'(exp_done));
    if (blk_done) n_done++;
    if (!in_ready) n_stall++;
    wr = (exp_q.size() > 0) && !out_full;
    chk("out_wrreq", 32'(out_wrreq), 32'(wr));
    exp_done = 1'b0;
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      chk("out_data", 32'(out_data), 32'(f.d));
      chk("out_last", 32'(out_last), 32'(f.l));
      if (wr) begin
        void'(exp_q.pop_front());
        n_writes++;
        exp_done = f.l;
      end
    end
    accepted = in_valid && exp_ready;
    if (accepted) begin
      for (int s = 0; s < 3; s++) m_byte[s] = m_byte[s] | (8'(in_d[s]) << m_cnt);
      m_cnt++;
      if (m_cnt == 8 || in_last) begin
        exp_q.push_back('{d: m_byte[0], l: 1'b0});
        exp_q.push_back('{d: m_byte[1], l: 1'b0});
        exp_q.push_back('{d: m_byte[2], l: in_last});
        m_cnt = 0;
        for (int s = 0; s < 3; s++) m_byte[s] = 8'h00;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] d, input logic last);
    bit a;
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_d     = d;
    in_last  = last;
    do begin
      tick(a);
      n++;
    end while (!a && n < 50);
    if (!a) chk("accept_timeout", 32'(a), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_wrreq", 32'(out_wrreq), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_blk_done", 32'(blk_done), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int  w0;
    int  d0;
    bit  a;
    vectors     = 0;
    miscompares = 0;
    n_writes    = 0;
    n_done      = 0;
    n_stall     = 0;
    in_valid    = 1'b0;
    in_d        = 3'b000;
    in_last     = 1'b0;
    out_full    = 1'b0;
    reset       = 1'b0;
    #1;
    do_reset();

    // d0=1, d1=0, d2 alternating from 1 -> 0xFF, 0x00, 0x55
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 3'b101 : 3'b001, 1'b0);
    idle(5);

    // Full 1056-symbol block at line rate
    w0 = n_writes;
    d0 = n_done;
    n_stall = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 1056; i++) begin
      in_d    = 3'($urandom);
      in_last = (i == 1055);
      tick(a);
    end
    idle(6);
    chk("blk1056_writes", 32'(n_writes - w0), 32'd396);
    chk("blk1056_done", 32'(n_done - d0), 32'd1);
    chk("blk1056_stalls", 32'(n_stall), 32'd0);

    // Short 3-symbol block -> 0x07, 0x02, 0x01
    send(3'b101, 1'b0);
    send(3'b011, 1'b0);
    send(3'b001, 1'b1);
    idle(6);

    // Back-pressure while symbols keep streaming
    n_stall  = 0;
    out_full = 1'b1;
    in_valid = 1'b1;
    in_d     = 3'($urandom);
    for (int i = 0; i < 20; i++) begin
      tick(a);
      if (a) in_d = 3'($urandom);
    end
    chk("bp_stall_seen", 32'(n_stall > 0), 32'd1);
    out_full = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) send(3'($urandom), 1'b0);
    send(3'($urandom), 1'b1);
    idle(8);

    // Back-to-back one-bit groups
    for (int i = 0; i < 6; i++) send(3'($urandom), 1'b1);
    idle(6);

    // Reset mid-group, then mid-drain (state S1)
    for (int i = 0; i < 5; i++) send(3'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) send(3'($urandom), 1'b0);
    idle(1);
    do_reset();
    idle(3);
    for (int i = 0; i < 8; i++) send(3'($urandom), 1'b0);
    idle(6);
    chk("final_drained", 32'(out_wrreq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_out_packer.md
# conv_out_packer

Downstream neighbour of the tail-biting convolutional encoder. Accepts the encoder's three coded bit streams (d0, d1, d2), one 3-bit symbol per cycle. Packs each stream LSB-first into bytes and writes them into the byte-wide output FIFO in the order d0, d1, d2. Handles back-pressure from that FIFO and zero-pads the final partial byte of each code block.

## Interface
- NUM_STREAMS, 3, coded streams per input symbol; fixed, not for override.
- BYTE_W, 8, output word width.
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  in_d holds a valid coded symbol.
- in_d  input  3  bit 0 = d0, bit 1 = d1, bit 2 = d2 (the encoder's dOut).
- in_last  input  1  qualifies the final symbol of a code block; meaningful only with in_valid.
- in_ready  output  1  block accepts in_d this cycle.
- out_full  input  1  output FIFO full.
- out_wrreq  output  1  write strobe to output FIFO.
- out_data  output  8  byte to write.
- out_last  output  1  high with the d2 byte of a block's final group.
- blk_done  output  1  one-cycle pulse when the out_last write is accepted.

## Operation
- Symbol accepted when in_valid && in_ready. Each accepted symbol shifts d0/d1/d2 into three 8-bit accumulators at position bit_cnt. The first bit of a group lands in bit 0.
- bit_cnt is 3 bits and wraps 7→0.
- Group completes on an accepted symbol when bit_cnt==7 or in_last==1. On completion:
  - the three bytes (current bits included) are copied to hold registers;
  - unfilled upper bits are 0;
  - accumulators and bit_cnt clear;
  - hold_last latches in_last.
- Drain FSM:
  - IDLE: hold empty. A completed group moves to S0.
  - S0: out_data = hold d0.
  - S1: out_data = hold d1.
  - S2: out_data = hold d2; out_last = hold_last.
  - Each state advances when the write is accepted. S2 returns to IDLE, or to S0 if a new group completed in the same cycle.
  - Only a write acceptance (out_wrreq && !out_full) advances the FSM.
- out_wrreq = (state != IDLE) && !out_full. It never asserts while out_full is high.
- in_ready = !(hold busy && (bit_cnt==7 || in_last)) || (state==S2 && !out_full). A completing symbol waits until the hold registers free up. Non-completing symbols keep flowing while the FSM drains.
- in_ready depends combinationally on in_last and out_full. No other combinational paths from inputs to outputs.
- blk_done pulses in the cycle after the S2 write with hold_last=1 is accepted.
- Reset values: in_ready=1, out_wrreq=0, out_data=0x00, out_last=0, blk_done=0, FSM=IDLE, bit_cnt=0.
- Reset mid-block discards all partial and held data; no write occurs after reset deasserts until a new group completes.
- in_last with bit_cnt==0 produces a one-bit group: bit 0 of each byte is data, bits 7:1 are zero.
- Code block lengths 1056 and 6144 are multiples of 8, so they produce no padding. Any length ≥1 is legal.

## Timing
- Latency from the completing symbol's accept edge to the d0 write: out_wrreq is high in the next cycle when out_full is low.
- Sustained throughput with out_full low: 1 symbol/cycle, 3 writes per 8 symbols. No stall occurs at steady state because the 3-cycle drain finishes before the next group completes.
- A stall occurs only under back-pressure, or with groups shorter than 3 symbols (in_last).
- out_data and out_last are registered and stable for as long as out_wrreq is held off by out_full.

## Structure
- Shared include/package holds NUM_STREAMS, BYTE_W, FSM state encodings (IDLE, S0, S1, S2), and the stream index constants D0/D1/D2.
- Sub-module stream_acc8: one 8-bit LSB-first accumulator with bit write, clear and parallel read. Instantiated three times.
- Top level contains bit_cnt, hold registers, drain FSM and handshake logic.

## Test plan
- Out of reset: all outputs at their reset values. Send 8 symbols with d0=1, d1=0 and d2 alternating 1,0,… starting at 1, no backpressure. Expect writes 0xFF, 0x00, 0x55 on consecutive cycles starting 1 cycle after the 8th accept, and out_last=0.
- 1056-symbol block, in_last on the final symbol, random data, out_full=0. Expect 396 writes matching the reference model, out_last only on write 396, blk_done one pulse, in_ready never low.
- Short block of 3 symbols: d0 bits 1,1,1; d1 0,1,0; d2 1,0,0; in_last on the 3rd. Expect 0x07, 0x02, 0x01 with out_last on 0x01.
- Hold out_full=1 for 20 cycles while symbols stream. Expect out_wrreq=0 throughout, and in_ready to drop when bit_cnt==7 with hold busy. Expect no data loss or reordering after release.
- Back-to-back in_last groups of length 1 with out_full=0. Expect in_ready to drop for the required cycles, and every write triple to carry a one-bit group padded with zeros.
- Assert reset mid-group (bit_cnt=5) and mid-drain (S1). Expect immediate IDLE and out_wrreq=0. The next 8-symbol group is emitted with no residue from before reset.
